led_flash_multi: RTL

Multi-channel, parametrised LED indicator driver for front-panel and status LEDs. Each channel has a runtime-selectable mode: stretch, blink, N-pulse burst, or direct. Each channel has its own period, so one instance replaces a bank of single-channel stretchers. Sits between status sources (PTT, ADC overload, Ethernet activity, etc.) and the LED output pins.

---
 rtl/led_flash_pkg.sv | 15 +
 rtl/led_flash_chan.sv | 133 +++++++++++++
 rtl/led_flash_multi.sv | 41 ++++
 3 files changed

// File: rtl/led_flash_pkg.sv
// Shared mode encodings and burst state type for the multi-channel LED flasher.
package led_flash_pkg;

  localparam logic [1:0] MODE_STRETCH = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_BURST   = 2'b10;
  localparam logic [1:0] MODE_DIRECT  = 2'b11;

  typedef enum logic [1:0] {
    BURST_IDLE = 2'b00,
    BURST_ON   = 2'b01,
    BURST_OFF  = 2'b10
  } burst_state_e;

endpackage

// File: rtl/led_flash_chan.sv
// Single LED channel: period counter, stretch/blink/burst/direct behaviour.
// Output is the raw lit state; pin polarity is applied by the top level.
module led_flash_chan
  import led_flash_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_signal,
  input  logic [1:0]         i_mode,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_led
);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_sig_q;
  logic [1:0]         r_mode_q;
  burst_state_e       r_state;
  logic [BURST_W-1:0] r_remaining;
  logic               r_led;
  logic               w_rise;
  logic               w_at_period;

  assign w_rise      = i_signal & ~r_sig_q;
  assign w_at_period = (r_cnt == i_period);
  assign o_led       = r_led;

  // Channel state: enable low beats a mode change, which beats the mode logic.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_led       <= 1'b0;
      r_cnt       <= '0;
      r_sig_q     <= 1'b0;
      r_mode_q    <= 2'b00;
      r_state     <= BURST_IDLE;
      r_remaining <= '0;
    end else begin
      r_sig_q  <= i_signal;
      r_mode_q <= i_mode;
      if (!i_enable) begin
        r_led       <= 1'b0;
        r_cnt       <= '0;
        r_state     <= BURST_IDLE;
        r_remaining <= '0;
      end else if (i_mode != r_mode_q) begin
        r_led   <= 1'b0;
        r_cnt   <= '0;
        r_state <= BURST_IDLE;
      end else begin
        case (i_mode)
          MODE_STRETCH: begin
            if (i_signal) begin
              r_cnt <= '0;
              r_led <= 1'b1;
            end else if (w_at_period) begin
              r_led <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          MODE_BLINK: begin
            if (!i_signal) begin
              r_led <= 1'b0;
              r_cnt <= '0;
            end else if (!r_sig_q) begin
              r_led <= 1'b1;
              r_cnt <= '0;
            end else if (w_at_period) begin
              r_led <= ~r_led;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          MODE_BURST: begin
            // remaining is latched at trigger so a live burst_len change cannot stretch a burst
            case (r_state)
              BURST_IDLE: begin
                if (w_rise && (i_burst_len != '0)) begin
                  r_led       <= 1'b1;
                  r_cnt       <= '0;
                  r_remaining <= i_burst_len;
                  r_state     <= BURST_ON;
                end else begin
                  r_state <= BURST_IDLE;
                end
              end
              BURST_ON: begin
                if (w_at_period) begin
                  r_led   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= BURST_OFF;
                end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end
              end
              BURST_OFF: begin
                if (!w_at_period) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end else if (r_remaining == BURST_W'(1)) begin
                  r_state <= BURST_IDLE;
                end else begin
                  r_remaining <= r_remaining - BURST_W'(1);
                  r_led       <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= BURST_ON;
                end
              end
              default: begin
                r_led   <= 1'b0;
                r_cnt   <= '0;
                r_state <= BURST_IDLE;
              end
            endcase
          end
          MODE_DIRECT: begin
            r_led <= i_signal;
            r_cnt <= '0;
          end
          default: begin
            r_led <= 1'b0;
            r_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/led_flash_multi.sv
// Bank of independent LED channels; slices the per-channel buses and applies
// the pin polarity without adding latency.
module led_flash_multi
  import led_flash_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 24,
  parameter int BURST_W    = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       signal,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CNT_W*CHANNELS-1:0] period,
  input  logic [BURST_W-1:0]        burst_len,
  output logic [CHANNELS-1:0]       LED
);

  logic [CHANNELS-1:0] w_led_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    led_flash_chan #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_chan (
      .i_clock     (clock),
      .i_reset_n   (reset_n),
      .i_enable    (enable),
      .i_signal    (signal[gi]),
      .i_mode      (mode[2*gi +: 2]),
      .i_period    (period[CNT_W*gi +: CNT_W]),
      .i_burst_len (burst_len),
      .o_led       (w_led_q[gi])
    );
  end

  assign LED = w_led_q ^ {CHANNELS{ACTIVE_LOW}};

endmodule
